alu_share_arbiter: RTL and testbench

//   Shares one ALU32Bit instance between two requesters. Arbitrates round-robin and

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external ALU between two requesters.
// Each operation is sequenced IDLE -> EXEC -> RESP; the response carries the requester id and the registered ALU flags.
module alu_share_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter logic        PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             id_q;
    logic             rsp_valid_q, rsp_id_q, rsp_cout_q, rsp_zero_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic grant0, grant1, op_illegal, op_sub;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign op_illegal = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
    assign op_sub     = (op_q == 3'b110) || (op_q == 3'b111);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        alu_cin = 1'b0;
        if (state_q == EXEC) begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_op  = op_illegal ? 3'b000 : op_q;
            alu_cin = op_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ~PRIO_INIT;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q          <= grant1 ? req1_a  : req0_a;
                        b_q          <= grant1 ? req1_b  : req0_b;
                        op_q         <= grant1 ? req1_op : req0_op;
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    if (op_illegal) begin
                        rsp_result_q <= '0;
                        rsp_cout_q   <= 1'b0;
                        rsp_zero_q   <= 1'b1;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_cout_q   <= alu_cout;
                        rsp_zero_q   <= alu_zero;
                        rsp_err_q    <= 1'b0;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached to the ALU pins.
module tb_alu_share_arbiter;
    localparam int W = 32;
    localparam logic PRIO = 1'b0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic v[2];
    logic [W-1:0] ra[2], rb[2];
    logic [2:0] rop[2];
    logic rsp_ready;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_err, busy;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic alu_cin, alu_cout, alu_zero;

    alu_share_arbiter #(.WIDTH(W), .PRIO_INIT(PRIO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural ALU32Bit: subtract-style ops add ~b plus the carry-in
    logic [32:0] s;
    always_comb begin
        s = '0;
        alu_result = '0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_cin};
                alu_result = s[31:0];
                alu_cout = s[32];
            end
            3'b110, 3'b111: begin
                s = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'b0, alu_cin};
                alu_result = (alu_op == 3'b110) ? s[31:0] : {31'b0, $signed(alu_a) < $signed(alu_b)};
                alu_cout = s[32];
            end
            default: ;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic id; logic [31:0] res; logic cout, zero, err;
        int unsigned acc; logic [31:0] aa, ab; logic [2:0] aop; logic acin;
    } exp_t;
    typedef struct { logic [2:0] op; logic [31:0] a, b; } op_t;

    exp_t sb[$];
    op_t src0[$], src1[$];
    int tests = 0, fails = 0;
    int unsigned cyc = 0, idle_cyc = 0;
    logic m_lg = ~PRIO;
    logic prev_rv = 1'b0;
    logic rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int unsigned acc);
        exp_t e;
        e.id = id; e.acc = acc; e.aa = a; e.ab = b; e.err = 1'b0; e.cout = 1'b0;
        e.aop = op; e.acin = (op == 3'b110) || (op == 3'b111);
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin e.res = a + b; e.cout = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; end
            3'b110: begin e.res = a - b; e.cout = (a >= b); end
            3'b111: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.cout = (a >= b); end
            default: begin e.res = 0; e.err = 1'b1; e.aop = 3'b000; end
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Request-side monitor: expected grant from the round-robin rule, pushes the scoreboard
    always @(negedge clk) if (!reset) begin
        int w;
        logic idle;
        idle = (sb.size() == 0) && (cyc >= idle_cyc);
        w = -1;
        if (v[0] && v[1]) w = m_lg ? 0 : 1;
        else if (v[0]) w = 0;
        else if (v[1]) w = 1;
        if (!idle) w = -1;
        check("ready", {62'b0, req0_ready, req1_ready}, {62'b0, w == 0, w == 1});
        if (w >= 0) begin
            sb.push_back(model(w[0], rop[w], ra[w], rb[w], cyc));
            m_lg = w[0];
        end
    end

    // Response-side monitor
    always @(negedge clk) if (!reset) begin
        logic has;
        exp_t e;
        has = (sb.size() != 0);
        if (has) e = sb[0];
        check("busy", {63'b0, busy}, {63'b0, has && cyc > e.acc});
        if (has && cyc == e.acc + 1) begin
            check("exec_ab", {alu_a, alu_b}, {e.aa, e.ab});
            check("exec_op_cin", {60'b0, alu_op, alu_cin}, {60'b0, e.aop, e.acin});
        end else begin
            check("alu_idle_ab", {alu_a, alu_b}, 64'd0);
            check("alu_idle_op", {60'b0, alu_op, alu_cin}, 64'd0);
        end
        if (!has) check("no_rsp_without_op", {63'b0, rsp_valid}, 64'd0);
        else if (cyc >= e.acc + 2) check("rsp_valid_on_time", {63'b0, rsp_valid}, 64'd1);
        if (has && rsp_valid) begin
            if (!prev_rv) check("latency", 64'(cyc - e.acc), 64'd2);
            check("rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
            check("rsp_result", {32'b0, rsp_result}, {32'b0, e.res});
            check("rsp_flags", {61'b0, rsp_cout, rsp_zero, rsp_err}, {61'b0, e.cout, e.zero, e.err});
            if (rsp_ready) begin
                void'(sb.pop_front());
                idle_cyc = cyc + 1;
            end
        end
        prev_rv = rsp_valid;
    end

    // Requester drivers: hold valid and payload until the handshake
    initial begin
        logic acc0, acc1;
        op_t o;
        v[0] = 1'b0; v[1] = 1'b0;
        ra[0] = '0; rb[0] = '0; rop[0] = '0;
        ra[1] = '0; rb[1] = '0; rop[1] = '0;
        forever begin
            @(negedge clk);
            acc0 = v[0] && req0_ready;
            acc1 = v[1] && req1_ready;
            @(posedge clk); #1;
            if (acc0) v[0] = 1'b0;
            if (acc1) v[1] = 1'b0;
            if (!v[0] && src0.size() != 0) begin
                o = src0.pop_front(); v[0] = 1'b1; ra[0] = o.a; rb[0] = o.b; rop[0] = o.op;
            end
            if (!v[1] && src1.size() != 0) begin
                o = src1.pop_front(); v[1] = 1'b1; ra[1] = o.a; rb[1] = o.b; rop[1] = o.op;
            end
            if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || v[0] || v[1] || sb.size() != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_done", 64'(sb.size() + src0.size() + src1.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_lg = ~PRIO;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cyc = 0;
    endtask

    initial begin
        int n;
        op_t o;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {56'b0, rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_err, busy, req0_ready, req1_ready}, 64'd0);
        check("reset_result", {32'b0, rsp_result}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        src0.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0001});
        drain(50);

        do_reset();
        src0.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0F0F_0F0F});
        src1.push_back('{3'b001, 32'hAAAA_AAAA, 32'h5555_5555});
        drain(50);

        for (int i = 0; i < 2; i++) begin
            src0.push_back('{3'b010, 32'(i * 7 + 3), 32'h1234_0000});
            src1.push_back('{3'b110, 32'(i), 32'h0000_0005});
        end
        drain(80);

        src1.push_back('{3'b110, 32'h2000_0000, 32'h1000_0000});
        src0.push_back('{3'b111, 32'h0000_0001, 32'h0000_0010});
        drain(50);

        rsp_ready = 1'b0;
        src0.push_back('{3'b010, 32'h0000_0010, 32'h0000_0020});
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("hold_rsp_seen", {63'b0, rsp_valid}, 64'd1);
        src1.push_back('{3'b001, 32'h0000_00F0, 32'h0000_000F});
        repeat (5) begin
            @(negedge clk);
            check("hold_state", {61'b0, busy, req0_ready, req1_ready}, 64'd4);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("hold_release_idle", {63'b0, rsp_valid}, 64'd0);
        drain(50);

        src0.push_back('{3'b100, 32'h1234_5678, 32'h1234_5678});
        drain(50);

        src0.push_back('{3'b010, 32'h0000_0001, 32'h0000_0002});
        n = 0;
        while (sb.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
        check("exec_reached", 64'(sb.size()), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_lg = ~PRIO;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cyc = 0;
        @(negedge clk);
        check("reset_mid_op", {62'b0, rsp_valid, busy}, 64'd0);
        repeat (10) @(negedge clk);

        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            o.op = 3'($urandom_range(0, 7));
            o.a = (i % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
            o.b = (i % 11 == 0) ? o.a : $urandom;
            if ($urandom_range(0, 1) == 0) src0.push_back(o);
            else src1.push_back(o);
        end
        drain(3000);
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
